// File: rtl/lsu.sv
// Load/store unit: one word-aligned data-memory access per request, with byte-lane
// steering for stores, sign/zero extension for loads and misalignment rejection.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       instr_in,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  input  logic [4:0]       rd_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             done,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign
);

  // Shared instruction encoding for the memory operations.
  localparam logic [5:0] I_LB  = 6'h10;
  localparam logic [5:0] I_LH  = 6'h11;
  localparam logic [5:0] I_LW  = 6'h12;
  localparam logic [5:0] I_LBU = 6'h13;
  localparam logic [5:0] I_LHU = 6'h14;
  localparam logic [5:0] I_SB  = 6'h18;
  localparam logic [5:0] I_SH  = 6'h19;
  localparam logic [5:0] I_SW  = 6'h1A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t      state;
  logic        load_reg;
  logic        unsigned_reg;
  size_t       size_reg;
  logic [1:0]  off_reg;
  logic [4:0]  rd_reg;

  // Decode of the incoming request.
  logic        dec_mem;
  logic        dec_load;
  logic        dec_unsigned;
  size_t       dec_size;
  logic        dec_misalign;
  logic [1:0]  off;
  logic [31:0] steer_wdata;
  logic [3:0]  steer_wstrb;

  assign off = addr[1:0];

  always_comb begin
    dec_mem      = 1'b1;
    dec_load     = 1'b0;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    unique case (instr_in)
      I_LB:    begin dec_load = 1'b1; dec_size = SZ_BYTE; end
      I_LBU:   begin dec_load = 1'b1; dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
      I_LH:    begin dec_load = 1'b1; dec_size = SZ_HALF; end
      I_LHU:   begin dec_load = 1'b1; dec_size = SZ_HALF; dec_unsigned = 1'b1; end
      I_LW:    begin dec_load = 1'b1; dec_size = SZ_WORD; end
      I_SB:    dec_size = SZ_BYTE;
      I_SH:    dec_size = SZ_HALF;
      I_SW:    dec_size = SZ_WORD;
      default: dec_mem = 1'b0;
    endcase
  end

  always_comb begin
    dec_misalign = 1'b0;
    case (dec_size)
      SZ_HALF: dec_misalign = off[0];
      SZ_WORD: dec_misalign = (off != 2'b00);
      default: dec_misalign = 1'b0;
    endcase
  end

  // Stores replicate the datum across lanes; the strobe picks the lane(s) written.
  always_comb begin
    steer_wdata = store_data;
    steer_wstrb = 4'b1111;
    case (dec_size)
      SZ_BYTE: begin
        steer_wdata = {4{store_data[7:0]}};
        steer_wstrb = 4'b0001 << off;
      end
      SZ_HALF: begin
        steer_wdata = {2{store_data[15:0]}};
        steer_wstrb = 4'b0011 << off;
      end
      default: begin
        steer_wdata = store_data;
        steer_wstrb = 4'b1111;
      end
    endcase
  end

  // Lane extraction and extension of the returned word.
  logic [31:0] rdata_shifted;
  logic [31:0] load_result;

  assign rdata_shifted = mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_result = mem_rdata;
    case (size_reg)
      SZ_BYTE: load_result = unsigned_reg ? {24'd0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_result = unsigned_reg ? {16'd0, rdata_shifted[15:0]}
                                          : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_result = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= 4'b0000;
      done         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      misalign     <= 1'b0;
      load_reg     <= 1'b0;
      unsigned_reg <= 1'b0;
      size_reg     <= SZ_WORD;
      off_reg      <= 2'b00;
      rd_reg       <= 5'd0;
    end else begin
      misalign <= 1'b0;
      done     <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && dec_mem) begin
            load_reg     <= dec_load;
            unsigned_reg <= dec_unsigned;
            size_reg     <= dec_size;
            off_reg      <= off;
            rd_reg       <= rd_in;
            if (dec_misalign) begin
              misalign <= 1'b1;
            end else begin
              state     <= ACCESS;
              req_ready <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= ~dec_load;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_wdata <= steer_wdata;
              mem_wstrb <= dec_load ? 4'b0000 : steer_wstrb;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (load_reg) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_reg;
              wb_data  <= load_result;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: store steering, load extension, wait states,
// misalignment rejection and asynchronous reset during an access.
module tb_lsu;

  localparam logic [5:0] I_LB  = 6'h10;
  localparam logic [5:0] I_LH  = 6'h11;
  localparam logic [5:0] I_LW  = 6'h12;
  localparam logic [5:0] I_LBU = 6'h13;
  localparam logic [5:0] I_LHU = 6'h14;
  localparam logic [5:0] I_SB  = 6'h18;
  localparam logic [5:0] I_SH  = 6'h19;
  localparam logic [5:0] I_SW  = 6'h1A;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  instr_in;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .instr_in(instr_in), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Issue one aligned request at a falling edge and serve it after `waits`
  // stall cycles; checks the bus every ACCESS cycle and the completion cycle.
  task automatic run_req(input string name, input logic [5:0] code, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input logic exp_we,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                         input logic exp_wbv, input logic [4:0] exp_rd,
                         input logic [31:0] exp_wbdata);
    req_valid = 1'b1; instr_in = code; addr = a; store_data = sd; rd_in = rd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      check({name, " req_ready_access"}, 32'(req_ready), 32'd0);
      check({name, " mem_req"},   32'(mem_req), 32'd1);
      check({name, " mem_we"},    32'(mem_we), 32'(exp_we));
      check({name, " mem_addr"},  mem_addr, {a[31:2], 2'b00});
      check({name, " mem_wdata"}, mem_wdata, exp_wdata);
      check({name, " mem_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
      check({name, " done_early"}, 32'(done), 32'd0);
      if (k == waits) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    check({name, " done"},     32'(done), 32'd1);
    check({name, " wb_valid"}, 32'(wb_valid), 32'(exp_wbv));
    check({name, " mem_req_off"}, 32'(mem_req), 32'd0);
    check({name, " wb_rd"},    32'(wb_rd), 32'(exp_rd));
    check({name, " wb_data"},  wb_data, exp_wbdata);
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " req_ready"},  32'(req_ready), 32'd1);
    $display("txn %s code=%h addr=%h waits=%0d wb_data=%h", name, code, a, waits, wb_data);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; instr_in = 6'd0; addr = 32'd0; store_data = 32'd0;
    rd_in = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst mem_req",   32'(mem_req), 32'd0);
    check("rst mem_we",    32'(mem_we), 32'd0);
    check("rst done",      32'(done), 32'd0);
    check("rst wb_valid",  32'(wb_valid), 32'd0);
    check("rst misalign",  32'(misalign), 32'd0);
    check("rst mem_addr",  mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst wb_rd",     32'(wb_rd), 32'd0);
    check("rst wb_data",   wb_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req("sw",  I_SW,  32'h100, 32'hDEADBEEF, 5'd3, 0, 32'h0,
            1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 32'd0);
    run_req("sb",  I_SB,  32'h203, 32'h000000A5, 5'd3, 1, 32'h0,
            1'b1, 32'hA5A5A5A5, 4'b1000, 1'b0, 5'd0, 32'd0);
    run_req("sh",  I_SH,  32'h702, 32'h1234BEEF, 5'd3, 0, 32'h0,
            1'b1, 32'hBEEFBEEF, 4'b1100, 1'b0, 5'd0, 32'd0);
    run_req("lb",  I_LB,  32'h302, 32'h0, 5'd7, 0, 32'h12F07856,
            1'b0, 32'h0, 4'b0000, 1'b1, 5'd7, 32'hFFFFFFF0);
    run_req("lbu", I_LBU, 32'h302, 32'h0, 5'd7, 0, 32'h12F07856,
            1'b0, 32'h0, 4'b0000, 1'b1, 5'd7, 32'h000000F0);
    run_req("lh",  I_LH,  32'h402, 32'h0, 5'd9, 3, 32'h80011234,
            1'b0, 32'h0, 4'b0000, 1'b1, 5'd9, 32'hFFFF8001);
    run_req("lhu", I_LHU, 32'h400, 32'h0, 5'd12, 0, 32'h80019234,
            1'b0, 32'h0, 4'b0000, 1'b1, 5'd12, 32'h00009234);
    run_req("lw",  I_LW,  32'h504, 32'h0, 5'd31, 2, 32'hCAFEF00D,
            1'b0, 32'h0, 4'b0000, 1'b1, 5'd31, 32'hCAFEF00D);
    // A store leaves the last load result on the writeback port.
    run_req("sw2", I_SW,  32'h508, 32'h11223344, 5'd1, 0, 32'h0,
            1'b1, 32'h11223344, 4'hF, 1'b0, 5'd31, 32'hCAFEF00D);

    // Misaligned word load: pulse only, no memory traffic.
    req_valid = 1'b1; instr_in = I_LW; addr = 32'h502; rd_in = 5'd4;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("mis misalign",  32'(misalign), 32'd1);
    check("mis req_ready", 32'(req_ready), 32'd1);
    check("mis mem_req",   32'(mem_req), 32'd0);
    @(negedge clk);
    check("mis pulse",     32'(misalign), 32'd0);
    check("mis mem_req2",  32'(mem_req), 32'd0);
    check("mis done",      32'(done), 32'd0);
    $display("txn lw_misaligned addr=%h", 32'h502);

    // Misaligned half store.
    req_valid = 1'b1; instr_in = I_SH; addr = 32'h601;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("mis_sh misalign", 32'(misalign), 32'd1);
    check("mis_sh mem_req",  32'(mem_req), 32'd0);
    $display("txn sh_misaligned addr=%h", 32'h601);

    // Non-memory code is swallowed.
    req_valid = 1'b1; instr_in = 6'h01; addr = 32'h800;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("nop mem_req",   32'(mem_req), 32'd0);
    check("nop req_ready", 32'(req_ready), 32'd1);
    check("nop misalign",  32'(misalign), 32'd0);
    $display("txn nop code=%h", 6'h01);

    // Reset in the middle of an access.
    req_valid = 1'b1; instr_in = I_LW; addr = 32'h900; rd_in = 5'd5;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("rstmid mem_req_before", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid mem_req",   32'(mem_req), 32'd0);
    check("rstmid req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid done",     32'(done), 32'd0);
      check("rstmid wb_valid", 32'(wb_valid), 32'd0);
      check("rstmid mem_req2", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    $display("txn lw_reset_abort addr=%h", 32'h900);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
